strobe_capture_fifo: RTL and testbench
======================================

Name: strobe_capture_fifo

Overview:
Consumes the single-cycle clk-domain strobe produced by the pulse synchronizer. Captures a data word from the slow domain on each strobe and buffers it in a small FIFO. Presents the buffered words to downstream clk-domain logic through a valid/ready interface. Also keeps a sticky overflow flag and a free-running strobe counter for debug.

Parameters:
DATA_W, 12, width of the captured data word
DEPTH, 4, FIFO depth in words; must be a power of 2, minimum 2
CNT_W, 16, width of the strobe counter

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
strobe_in  in  1  synchronized strobe from the pulse synchronizer; nominally 1 cycle high
data_in  in  DATA_W  slow-domain data word; stable whenever strobe_in is high
out_data  out  DATA_W  head-of-FIFO word; valid only while out_valid=1
out_valid  out  1  FIFO non-empty
out_ready  in  1  downstream accepts out_data this cycle
level  out  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
overflow  out  1  sticky; a strobe arrived while the FIFO was full
clear_ovf  in  1  synchronous clear of overflow
strobe_count  out  CNT_W  number of detected strobes, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, active-high): pointers, level, overflow, strobe_count and the edge-detect register all go to 0. out_valid=0. out_data=0 (array cleared).
- Strobe detect: push_req = strobe_in & ~strobe_d, where strobe_d is strobe_in registered. A strobe held high for several cycles produces exactly one push. Two pulses separated by one low cycle produce two pushes.
- Capture: data_in is sampled in the same cycle push_req=1. Data is written at wr_ptr on that clock edge.
- Pop: pop = out_valid & out_ready. rd_ptr advances on that clock edge.
- FIFO is first-word-fall-through:
  - out_data = mem[rd_ptr]
  - out_valid = (level != 0)
  - Latency from strobe_in high (cycle N, FIFO empty) to out_valid=1 is one cycle (N+1), with out_data = the captured word.
- Pointers have log2(DEPTH) bits and wrap DEPTH-1 -> 0. level is tracked as an explicit counter.
- Level update:
  - push accepted, no pop: level+1
  - pop, no push: level-1
  - both: level unchanged
- Full (level=DEPTH), push_req, no pop: word dropped, pointers unchanged, overflow set to 1.
- Full, push_req and pop in the same cycle: both succeed, level stays DEPTH, no overflow.
- Empty: out_ready is ignored. No underflow, and pointers do not move.
- overflow: set on a dropped push, cleared by clear_ovf. If set and clear happen in the same cycle, set wins.
- strobe_count increments on every push_req, including dropped ones. Wraps 2^CNT_W-1 -> 0.
- Reset mid-operation: all buffered data is discarded immediately. out_valid falls asynchronously with reset.

Decomposition:
- Shared package holds:
  - default DATA_W and DEPTH constants
  - a clog2-based pointer-width constant/function
  - the level width expression, so the pulse synchronizer's consumers agree on widths
- One sub-module, rise_detect (clk, reset, in -> pulse), holds the strobe_d register and edge logic. The FIFO storage and pointers stay inline.

Test Plan:
- Single strobe: strobe_in=1 for 1 cycle with data_in=0x5A3, out_ready=0 -> next cycle out_valid=1, out_data=0x5A3, level=1, strobe_count=1.
- Held strobe: strobe_in=1 for 3 cycles, data_in=0x001 -> exactly one push, level=1, strobe_count=1.
- Fill and overflow (DEPTH=4, out_ready=0): push 0x10,0x11,0x12,0x13 then 0x14 -> level=4, overflow=1, strobe_count=5. Draining yields 0x10..0x13 in order, then out_valid=0. clear_ovf=1 -> overflow=0.
- Full with simultaneous push/pop: FIFO holds 0x20..0x23, strobe with 0x24 while out_ready=1 -> 0x20 popped, level stays 4, overflow=0. Subsequent drain order is 0x21,0x22,0x23,0x24.
- Pointer wrap: 10 strobes with one pop per strobe, each push and pop in separate cycles -> each word emerges in order and level oscillates 0/1, exercising pointer wrap past DEPTH-1.
- Reset mid-operation: level=3, assert reset between clock edges -> out_valid, level, overflow and strobe_count read 0 immediately. After release, the first new strobe produces level=1 with the new data.

Source files
------------

// File: rtl/strobe_capture_fifo_pkg.sv
// Shared widths and defaults for the strobe capture FIFO and its consumers.
package strobe_capture_fifo_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_CNT_W  = 16;

  // Pointer width for a power-of-2 depth; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy needs one extra bit so that 0..DEPTH is representable.
  function automatic int level_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one-cycle pulse on each low-to-high transition of in.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic strobe_d_q;
  logic strobe_d_d;

  always_comb begin
    strobe_d_d = in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) strobe_d_q <= 1'b0;
    else       strobe_d_q <= strobe_d_d;
  end

  assign pulse = in & ~strobe_d_q;

endmodule

// File: rtl/strobe_capture_fifo.sv
// Captures data_in on each strobe rising edge into a first-word-fall-through FIFO,
// with a sticky overflow flag and a wrapping strobe counter for debug.
module strobe_capture_fifo
  import strobe_capture_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      strobe_in,
  input  logic [DATA_W-1:0]         data_in,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [level_w(DEPTH)-1:0] level,
  output logic                      overflow,
  input  logic                      clear_ovf,
  output logic [CNT_W-1:0]          strobe_count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic push_req, push, pop, full, drop;

  rise_detect u_rise_detect (
    .clk   (clk),
    .reset (reset),
    .in    (strobe_in),
    .pulse (push_req)
  );

  // Handshake: a word transfers on any clock edge where out_valid && out_ready;
  // out_data/out_valid depend only on state, never combinationally on out_ready.
  assign full = (level_q == LVL_W'(DEPTH));
  assign pop  = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = push_req & (~full | pop);
  assign drop = push_req & full & ~pop;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    count_d    = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (drop)           overflow_d = 1'b1;
    else if (clear_ovf) overflow_d = 1'b0;

    if (push_req) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  assign out_data     = mem_q[rd_ptr_q];
  assign out_valid    = (level_q != '0);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign strobe_count = count_q;

endmodule

// File: tb/tb_strobe_capture_fifo.sv
// Directed bench for strobe_capture_fifo with hand-computed expectations.
module tb_strobe_capture_fifo;

  localparam int DATA_W = 12;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam int LVL_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              strobe_in;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              clear_ovf;
  logic [CNT_W-1:0]  strobe_count;

  int n_pass  = 0;
  int n_total = 0;

  strobe_capture_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .strobe_in    (strobe_in),
    .data_in      (data_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .overflow     (overflow),
    .clear_ovf    (clear_ovf),
    .strobe_count (strobe_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Driver: one-cycle strobe followed by one low cycle.
  task automatic pulse(input logic [DATA_W-1:0] d);
    strobe_in = 1'b1;
    data_in   = d;
    tick();
    strobe_in = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    strobe_in = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", strobe_count, 0);
    chk("rst_data", out_data, 0);
    tick();
    reset = 1'b0;
    tick();

    // Single strobe: visible one cycle later
    strobe_in = 1'b1;
    data_in   = 12'h5A3;
    tick();
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 12'h5A3);
    chk("single_level", level, 1);
    chk("single_count", strobe_count, 1);
    strobe_in = 1'b0;
    tick();
    pop_one();
    chk("single_drain_level", level, 0);

    // Held strobe: exactly one push
    strobe_in = 1'b1;
    data_in   = 12'h001;
    tick(); tick(); tick();
    strobe_in = 1'b0;
    tick();
    chk("held_level", level, 1);
    chk("held_count", strobe_count, 2);
    chk("held_data", out_data, 12'h001);
    pop_one();
    chk("held_drain_level", level, 0);

    // Fill and overflow
    for (int i = 0; i < 5; i++) pulse(12'h010 + 12'(i));
    chk("fill_level", level, 4);
    chk("fill_ovf", overflow, 1);
    chk("fill_count", strobe_count, 7);
    for (int i = 0; i < 4; i++) begin
      chk("fill_drain_valid", out_valid, 1);
      chk("fill_drain_data", out_data, 12'h010 + i);
      pop_one();
    end
    chk("fill_empty_valid", out_valid, 0);
    chk("fill_empty_level", level, 0);
    pop_one();
    chk("empty_ready_level", level, 0);
    chk("empty_ready_valid", out_valid, 0);
    chk("ovf_sticky", overflow, 1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) pulse(12'h020 + 12'(i));
    chk("fullpp_pre_level", level, 4);
    strobe_in = 1'b1;
    data_in   = 12'h024;
    out_ready = 1'b1;
    tick();
    strobe_in = 1'b0;
    out_ready = 1'b0;
    chk("fullpp_level", level, 4);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_count", strobe_count, 12);
    chk("fullpp_head", out_data, 12'h021);
    tick();
    for (int i = 1; i < 5; i++) begin
      chk("fullpp_drain_data", out_data, 12'h020 + i);
      pop_one();
    end
    chk("fullpp_empty_valid", out_valid, 0);

    // Pointer wrap: alternating push and pop
    for (int i = 0; i < 10; i++) begin
      pulse(12'h030 + 12'(i));
      chk("wrap_level1", level, 1);
      chk("wrap_data", out_data, 12'h030 + i);
      pop_one();
      chk("wrap_level0", level, 0);
    end
    chk("wrap_count", strobe_count, 22);

    // Reset mid-operation
    pulse(12'h040);
    pulse(12'h041);
    pulse(12'h042);
    chk("midrst_pre_level", level, 3);
    chk("midrst_pre_count", strobe_count, 25);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_level", level, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_count", strobe_count, 0);
    tick();
    reset = 1'b0;
    strobe_in = 1'b1;
    data_in   = 12'h777;
    tick();
    strobe_in = 1'b0;
    chk("postrst_level", level, 1);
    chk("postrst_data", out_data, 12'h777);
    chk("postrst_count", strobe_count, 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
